// File: rtl/axis_gmii_rx_ctrl.sv
// Receive-side controller for an AXI-Stream GMII/MII MAC: enable handshake, speed-dependent
// clock-enable generation, frame watchdog and saturating receive statistics.
module axis_gmii_rx_ctrl #(
  parameter int unsigned CLK_DIV_100   = 5,
  parameter int unsigned CLK_DIV_10    = 50,
  parameter int unsigned TIMEOUT_WIDTH = 20,
  parameter int unsigned STAT_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_enable,
  input  logic [1:0]            cfg_speed,
  input  logic                  stat_clear,
  input  logic                  rx_start_packet,
  input  logic                  rx_error_bad_frame,
  input  logic                  rx_error_bad_fcs,
  input  logic                  rx_axis_tvalid,
  input  logic                  rx_axis_tlast,
  output logic                  rx_clk_enable,
  output logic                  rx_mii_select,
  output logic                  rx_cfg_rx_enable,
  output logic [1:0]            status_state,
  output logic [1:0]            status_speed,
  output logic [STAT_WIDTH-1:0] stat_frames,
  output logic [STAT_WIDTH-1:0] stat_bad_frame,
  output logic [STAT_WIDTH-1:0] stat_bad_fcs,
  output logic [STAT_WIDTH-1:0] stat_timeout
);

  localparam int unsigned DIV_MAX = (CLK_DIV_10 > CLK_DIV_100) ? CLK_DIV_10 : CLK_DIV_100;
  localparam int unsigned DIV_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam logic [STAT_WIDTH-1:0]    STAT_MAX = '1;
  // Watchdog fires on the cycle its increment would reach all-ones.
  localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST  = ~TIMEOUT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ENABLED  = 2'd1,
    ST_IN_FRAME = 2'd2,
    ST_DRAIN    = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [1:0]               speed_q, speed_d;
  logic [DIV_W-1:0]         div_q, div_d;
  logic [TIMEOUT_WIDTH-1:0] wd_q, wd_d;
  logic                     clk_en_q, clk_en_d;
  logic                     mii_q, mii_d;
  logic                     rx_en_q, rx_en_d;
  logic [STAT_WIDTH-1:0]    frames_q, frames_d;
  logic [STAT_WIDTH-1:0]    bad_frame_q, bad_frame_d;
  logic [STAT_WIDTH-1:0]    bad_fcs_q, bad_fcs_d;
  logic [STAT_WIDTH-1:0]    timeout_q, timeout_d;

  logic frame_end_c;
  logic frame_done_c;
  logic timeout_c;

  assign frame_end_c = rx_axis_tvalid & rx_axis_tlast;

  function automatic logic [DIV_W-1:0] div_last(input logic [1:0] spd);
    logic [DIV_W-1:0] last;
    if (spd == 2'b01) last = DIV_W'(CLK_DIV_100 - 1);
    else              last = DIV_W'(CLK_DIV_10 - 1);
    return last;
  endfunction

  function automatic logic [STAT_WIDTH-1:0] stat_next(input logic [STAT_WIDTH-1:0] cnt,
                                                      input logic                  inc,
                                                      input logic                  clr);
    logic [STAT_WIDTH-1:0] nxt;
    nxt = cnt;
    if (clr)                        nxt = inc ? STAT_WIDTH'(1) : '0;
    else if (inc && cnt != STAT_MAX) nxt = cnt + STAT_WIDTH'(1);
    return nxt;
  endfunction

  always_comb begin
    state_d      = state_q;
    speed_d      = speed_q;
    wd_d         = '0;
    frame_done_c = 1'b0;
    timeout_c    = 1'b0;

    case (state_q)
      ST_DISABLED: begin
        speed_d = cfg_speed;
        if (cfg_enable) state_d = ST_ENABLED;
      end
      ST_ENABLED: begin
        if (rx_start_packet)                             state_d = ST_IN_FRAME;
        else if (!cfg_enable || cfg_speed != speed_q)    state_d = ST_DISABLED;
      end
      ST_IN_FRAME: begin
        wd_d = wd_q + TIMEOUT_WIDTH'(1);
        if (frame_end_c) begin
          state_d      = ST_ENABLED;
          frame_done_c = 1'b1;
        end else if (wd_q == WD_LAST) begin
          state_d   = ST_DISABLED;
          timeout_c = 1'b1;
        end else if (!cfg_enable || cfg_speed != speed_q) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        wd_d = wd_q + TIMEOUT_WIDTH'(1);
        if (frame_end_c) begin
          state_d      = ST_DISABLED;
          frame_done_c = 1'b1;
        end else if (wd_q == WD_LAST) begin
          state_d   = ST_DISABLED;
          timeout_c = 1'b1;
        end
      end
      default: state_d = ST_DISABLED;
    endcase

    // Divider restarts on any speed change and idles at zero in gigabit mode.
    if (speed_d != speed_q)          div_d = '0;
    else if (speed_q[1])             div_d = '0;
    else if (div_q == div_last(speed_q)) div_d = '0;
    else                             div_d = div_q + DIV_W'(1);

    clk_en_d = speed_d[1] | (div_d == div_last(speed_d));
    mii_d    = ~speed_d[1];
    rx_en_d  = (state_d == ST_ENABLED) || (state_d == ST_IN_FRAME);

    frames_d    = stat_next(frames_q,    frame_done_c,       stat_clear);
    bad_frame_d = stat_next(bad_frame_q, rx_error_bad_frame, stat_clear);
    bad_fcs_d   = stat_next(bad_fcs_q,   rx_error_bad_fcs,   stat_clear);
    timeout_d   = stat_next(timeout_q,   timeout_c,          stat_clear);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_DISABLED;
      speed_q     <= 2'b10;
      div_q       <= '0;
      wd_q        <= '0;
      clk_en_q    <= 1'b1;
      mii_q       <= 1'b0;
      rx_en_q     <= 1'b0;
      frames_q    <= '0;
      bad_frame_q <= '0;
      bad_fcs_q   <= '0;
      timeout_q   <= '0;
    end else begin
      state_q     <= state_d;
      speed_q     <= speed_d;
      div_q       <= div_d;
      wd_q        <= wd_d;
      clk_en_q    <= clk_en_d;
      mii_q       <= mii_d;
      rx_en_q     <= rx_en_d;
      frames_q    <= frames_d;
      bad_frame_q <= bad_frame_d;
      bad_fcs_q   <= bad_fcs_d;
      timeout_q   <= timeout_d;
    end
  end

  assign rx_clk_enable    = clk_en_q;
  assign rx_mii_select    = mii_q;
  assign rx_cfg_rx_enable = rx_en_q;
  assign status_state     = state_q;
  assign status_speed     = speed_q;
  assign stat_frames      = frames_q;
  assign stat_bad_frame   = bad_frame_q;
  assign stat_bad_fcs     = bad_fcs_q;
  assign stat_timeout     = timeout_q;

endmodule
